// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: packet-locked round-robin arbiter feeding a one-deep registered output slice
module handshake_rr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ = 4,
  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          last_o,
  output logic [ID_W-1:0]               id_o,
  output logic                          valid_o,
  input  logic                          ready_i
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nx, lock_id, lock_id_nx, win;
  logic [ID_W:0] idx;
  logic win_ok, out_ready, xfer, win_last;
  always_comb begin
    win = lock_id;
    win_ok = req_valid_i[lock_id];
    idx = '0;
    if (state == IDLE) begin
      win_ok = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
        idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
        if (req_valid_i[idx[ID_W-1:0]]) begin
          win = idx[ID_W-1:0];
          win_ok = 1'b1;
        end
      end
    end
  end
  assign out_ready = !valid_o | ready_i;
  assign xfer = out_ready & win_ok;
  assign win_last = req_last_i[win];
  assign req_ready_o = xfer ? NUM_REQ'(1) << win : '0;
  always_comb begin
    state_nx = state;
    rr_ptr_nx = rr_ptr;
    lock_id_nx = lock_id;
    if (xfer && state == IDLE && !win_last) begin
      state_nx = LOCK;
      lock_id_nx = win;
    end
    if (xfer && win_last) begin
      state_nx = IDLE;
      rr_ptr_nx = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      rr_ptr <= '0;
      lock_id <= '0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_ptr_nx;
      lock_id <= lock_id_nx;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o <= '0;
      last_o <= 1'b0;
      id_o <= '0;
    end else if (out_ready) begin
      valid_o <= xfer;
      if (xfer) begin
        data_o <= req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
        last_o <= win_last;
        id_o <= win;
      end
    end
  end
endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the payload width per requester and on the output.
REQ-002 Parameter NUM_REQ, default 4, range 2..16, SHALL set the number of requesters.
REQ-003 Derived width ID_W SHALL equal max(1, clog2(NUM_REQ)).
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk_i  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst_ni  in  1  SHALL be the asynchronous active-low reset.
REQ-007 req_data_i  in  NUM_REQ*DATA_WIDTH  SHALL carry the payload; slice k SHALL be bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_valid_i  in  NUM_REQ  SHALL be the per-requester beat-valid signal.
REQ-009 req_last_i  in  NUM_REQ  SHALL mark the final beat of a packet, per requester.
REQ-010 req_ready_o  out  NUM_REQ  SHALL be the per-requester accept signal.
REQ-011 data_o  out  DATA_WIDTH  SHALL be the registered output payload.
REQ-012 last_o  out  1  SHALL be the registered last flag.
REQ-013 id_o  out  ID_W  SHALL be the registered index of the source requester.
REQ-014 valid_o  out  1  SHALL be the registered output valid.
REQ-015 ready_i  in  1  SHALL be the downstream accept signal.

Function
REQ-016 Internal out_ready SHALL equal (!valid_o | ready_i), giving a one-deep registered slice with full throughput.
REQ-017 State machine SHALL have two states: IDLE (arbitrating) and LOCK (packet in progress, source fixed to lock_id).
REQ-018 In IDLE, the winner SHALL be the first k with req_valid_i[k]=1, searched from rr_ptr upward and wrapping at NUM_REQ-1 to 0.
REQ-019 In LOCK, the winner SHALL be lock_id regardless of other valids; if req_valid_i[lock_id]=0, no beat SHALL be selected.
REQ-020 req_ready_o[k] SHALL equal out_ready & (k==winner) & (a winner exists); every other bit SHALL be 0.
REQ-021 req_ready_o SHALL be combinational from state, req_valid_i, valid_o and ready_i, and SHALL never depend on req_data_i or req_last_i.
REQ-022 A beat SHALL transfer on requester k when req_valid_i[k] & req_ready_o[k]; at most one transfer per cycle.
REQ-023 On transfer, the next edge SHALL load data_o, last_o and id_o from the winner and SHALL set valid_o=1.
REQ-024 When out_ready=1 and no beat transfers, valid_o SHALL clear to 0, and data_o, last_o and id_o SHALL hold.
REQ-025 When out_ready=0, all output registers SHALL hold.
REQ-026 Latency SHALL be 1 cycle from input transfer to valid_o.
REQ-027 Sustained throughput SHALL be 1 beat/cycle while ready_i=1.
REQ-028 IDLE with a transfer and last=0 SHALL go to LOCK, with lock_id set to the winner; rr_ptr SHALL be unchanged.
REQ-029 IDLE with a transfer and last=1 (single-beat packet) SHALL stay in IDLE, with rr_ptr set to (winner+1) mod NUM_REQ.
REQ-030 LOCK with a transfer and last=1 SHALL go to IDLE, with rr_ptr set to (lock_id+1) mod NUM_REQ.
REQ-031 LOCK with a transfer and last=0, or with no transfer, SHALL remain in LOCK.
REQ-032 Pointer wrap SHALL apply: a winner of NUM_REQ-1 SHALL yield rr_ptr=0.
REQ-033 For non-power-of-2 NUM_REQ, rr_ptr and lock_id SHALL never exceed NUM_REQ-1.
REQ-034 Priority SHALL rotate at packet granularity only; beats of different packets SHALL never interleave on the output.
REQ-035 A requester that deasserts valid mid-packet SHALL stall the output and SHALL keep the lock; no timeout applies.
REQ-036 Simultaneous requests SHALL be resolved by REQ-018 alone; a new request arriving during LOCK SHALL wait until last is accepted.

Reset
REQ-037 While rst_ni=0, valid_o SHALL be 0, data_o 0, last_o 0, id_o 0, state IDLE, rr_ptr 0 and lock_id 0, asynchronously.
REQ-038 req_ready_o SHALL be 1 in reset only through out_ready; the bench SHALL not drive valids during reset.
REQ-039 Reset asserted mid-packet SHALL discard the lock and any held beat; after release, arbitration SHALL restart from requester 0.

Verification
REQ-040 Reset release, all requesters valid with last=1, ready_i=1 -> id_o sequence 0,1,2,3,0,... one per cycle, valid_o continuous.
REQ-041 Requester 2 sends a 3-beat packet (D0,D1,D2, last on D2) while requesters 0, 1 and 3 hold valid -> output 2,2,2 with last_o only on D2, then ids 3,0,1.
REQ-042 ready_i=0 for 5 cycles while valid_o=1 -> data_o/id_o stable, req_ready_o=0; ready_i=1 -> stream resumes with no loss or duplication.
REQ-043 With NUM_REQ=3, rr_ptr=2 and only requester 2 valid (single beat) -> rr_ptr wraps to 0; next grant with requesters 0 and 1 valid goes to 0.
REQ-044 rst_ni pulsed low for 1 cycle during beat 2 of a 4-beat packet from requester 1 -> valid_o=0 immediately; after release, the lock is gone and requester 0 wins first if valid.
REQ-045 Random valid/last/ready_i over 10k cycles against a scoreboard -> per-source order preserved, packets unbroken, and no requester starved beyond NUM_REQ-1 packets.
